// File: rtl/div_pipe_8bit.sv
// div_pipe_8bit: fully pipelined unsigned restoring divider.
// One dividend/divisor pair is accepted per clock. Quotient and remainder
// come out size+1 cycles after capture, with a registered valid beside them.
// A zero divisor returns quotient all-ones, remainder = dividend and raises div_err.
module div_pipe_8bit #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_en_in,
  input  logic [size-1:0] div_a,
  input  logic [size-1:0] div_b,
  output logic            div_en_out,
  output logic [size-1:0] div_quo,
  output logic [size-1:0] div_rem,
  output logic            div_err
);

  // Stage 0 is the input register. Stages 1..size each retire one quotient bit.
  logic [size:0]   vld_q;                 // valid shift chain, bit i = stage i
  logic [size:0]   zero_q;                // zero-divisor flag per stage
  logic [size-1:0] rem_q [0:size];        // partial remainder, always < divisor
  logic [size-1:0] quo_q [0:size];        // partial quotient, filled MSB first
  logic [size-1:0] dvd_q [0:size-1];      // dividend bits still to shift in
  logic [size-1:0] dvs_q [0:size-1];      // divisor copy travelling with the op

  logic [size-1:0] rem_nxt [1:size];
  logic [size-1:0] quo_nxt [1:size];
  logic [size-1:0] dvd_nxt [1:size-1];
  logic [size:0]   r_shift;
  logic            ge;

  // One restoring-division step per stage, computed from the previous stage.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    r_shift = '0;
    ge      = 1'b0;
    for (int i = 1; i <= size; i++) begin
      rem_nxt[i] = '0;
      quo_nxt[i] = '0;
    end
    for (int i = 1; i < size; i++) begin
      dvd_nxt[i] = '0;
    end

    for (int i = 1; i <= size; i++) begin
      // The shifted remainder is size+1 bits wide, so the compare sees the
      // bit that falls off the top and cannot wrap.
      r_shift = {rem_q[i-1], dvd_q[i-1][size-1]};
      ge      = (r_shift >= {1'b0, dvs_q[i-1]});
      // When ge holds the true difference is < divisor < 2**size, so taking
      // the low size bits of the subtraction loses nothing.
      rem_nxt[i] = ge ? (r_shift[size-1:0] - dvs_q[i-1]) : r_shift[size-1:0];
      quo_nxt[i] = {quo_q[i-1][size-2:0], ge};
      if (i < size) begin
        dvd_nxt[i] = dvd_q[i-1] << 1;
      end
    end
  end

  // Pipeline registers: input capture, division stages and valid chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is a plain register bank (not a RAM), so clearing it
      // in reset is cheap and keeps stale operands from reaching the output.
      vld_q  <= '0;
      zero_q <= '0;
      for (int i = 0; i <= size; i++) begin
        rem_q[i] <= '0;
        quo_q[i] <= '0;
      end
      for (int i = 0; i < size; i++) begin
        dvd_q[i] <= '0;
        dvs_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so each stage
      // reads the previous stage's value from before this edge.
      vld_q <= {vld_q[size-1:0], div_en_in};

      // Idle cycles load zeros; their flag stays low and the output is gated anyway.
      rem_q[0]  <= '0;
      quo_q[0]  <= '0;
      dvd_q[0]  <= div_en_in ? div_a : '0;
      dvs_q[0]  <= div_en_in ? div_b : '0;
      zero_q[0] <= div_en_in && (div_b == '0);

      zero_q[size:1] <= zero_q[size-1:0];
      for (int i = 1; i <= size; i++) begin
        rem_q[i] <= rem_nxt[i];
        quo_q[i] <= quo_nxt[i];
      end
      for (int i = 1; i < size; i++) begin
        dvd_q[i] <= dvd_nxt[i];
        dvs_q[i] <= dvs_q[i-1];
      end
    end
  end

  // Output register: present the result only when a valid op arrives, else zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_en_out <= 1'b0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_err    <= 1'b0;
    end else if (vld_q[size]) begin
      div_en_out <= 1'b1;
      // With a zero divisor every step subtracts nothing and shifts the
      // dividend through, so the remainder is already div_a.
      div_quo    <= zero_q[size] ? '1 : quo_q[size];
      div_rem    <= rem_q[size];
      div_err    <= zero_q[size];
    end else begin
      div_en_out <= 1'b0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_pipe_8bit.sv
// Scoreboard testbench for div_pipe_8bit: the driver pushes the reference
// result with its due cycle; a negedge monitor pops and compares each output.
module tb_div_pipe_8bit;

  localparam int SIZE    = 8;
  localparam int LATENCY = SIZE + 1;

  logic            clk;
  logic            rst_n;
  logic            div_en_in;
  logic [SIZE-1:0] div_a;
  logic [SIZE-1:0] div_b;
  logic            div_en_out;
  logic [SIZE-1:0] div_quo;
  logic [SIZE-1:0] div_rem;
  logic            div_err;

  div_pipe_8bit #(.size(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_en_in  (div_en_in),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_en_out (div_en_out),
    .div_quo    (div_quo),
    .div_rem    (div_rem),
    .div_err    (div_err)
  );

  typedef struct {
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            err;
    int              due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division, zero divisor handled by rule.
  function automatic exp_t model(input int a, input int b, input int due);
    exp_t m;
    if (b == 0) begin
      m.q   = 8'hFF;
      m.r   = SIZE'(a);
      m.err = 1'b1;
    end else begin
      m.q   = SIZE'(a / b);
      m.r   = SIZE'(a % b);
      m.err = 1'b0;
    end
    m.due = due;
    return m;
  endfunction

  // Drive one operation; capture edge is the next posedge (cyc+1).
  task automatic issue(input int a, input int b);
    @(negedge clk);
    div_en_in = 1'b1;
    div_a     = SIZE'(a);
    div_b     = SIZE'(b);
    sb.push_back(model(a, b, cyc + 1 + LATENCY));
  endtask

  // Idle cycles with a zero divisor and random dividend on the bus.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      div_en_in = 1'b0;
      div_a     = SIZE'($urandom);
      div_b     = '0;
    end
  endtask

  // Wait for all outstanding results, bounded.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * LATENCY) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare every valid output against the scoreboard head; when
  // not valid the data outputs must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (div_en_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(div_en_out), 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("quo", div_quo, e.q);
          check("rem", div_rem, e.r);
          check("err", div_err, e.err);
        end
      end else begin
        check("idle_zero", {div_err, div_quo, div_rem}, 0);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    div_en_in = 1'b0;
    div_a     = '0;
    div_b     = '0;
    #1;
    check("reset_state", {div_en_out, div_err, div_quo, div_rem}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single operation, then outputs return to zero.
    issue(200, 7);
    idle(LATENCY + 3);
    drain();

    // Boundary values with varying gaps.
    issue(255, 1);   idle(1);
    issue(5, 9);     idle(2);
    issue(0, 13);    idle(3);
    issue(255, 255); idle(1);
    issue(128, 2);   idle(2);
    drain();

    // Divide by zero followed by a normal op, then a long idle with b=0.
    issue(37, 0);
    issue(100, 3);
    idle(30);
    drain();

    // Back-to-back random stream including zero divisors.
    for (int i = 0; i < 64; i++) begin
      issue($urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
    end
    idle(1);
    drain();
    idle(3);

    // Reset mid-flight: four ops in flight, fifth presented while in reset.
    for (int i = 0; i < 4; i++) issue(50 + i, 3 + i);
    @(negedge clk);
    div_en_in = 1'b1;
    div_a     = 8'd99;
    div_b     = 8'd5;
    rst_n     = 1'b0;
    sb.delete();
    #1;
    check("reset_flush", {div_en_out, div_err, div_quo, div_rem}, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    div_en_in = 1'b0;
    idle(LATENCY + 4);
    issue(9, 4);
    idle(1);
    drain();
    idle(2);

    // Exhaustive sweep streamed continuously.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        issue(a, b);
      end
    end
    idle(1);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
